// File: rtl/tx_pkg.sv
// Shared definitions for the UART word sequencer: FSM encoding and the
// bytes-per-word derivation.
package tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Number of UART bytes that make up one upstream word (MAXB).
  function automatic int calc_maxb(input int nb_word, input int nb_data);
    return nb_word / nb_data;
  endfunction

endpackage

// File: rtl/tx_word_sequencer_if.sv
// Upstream word handshake: the debug/readback side offers a word and a byte
// count; the sequencer answers with ready.
interface tx_word_sequencer_if #(
  parameter int NB_WORD  = 32,
  parameter int NB_COUNT = 3
);
  logic [NB_WORD-1:0]  word_data;
  logic [NB_COUNT-1:0] byte_count;
  logic                word_valid;
  logic                word_ready;

  modport master (output word_data, output byte_count, output word_valid, input word_ready);
  modport slave  (input word_data, input byte_count, input word_valid, output word_ready);
endinterface

// File: rtl/tx_word_sequencer.sv
// Splits one accepted word into 1..MAXB bytes, LSB first, and feeds them to a
// byte-wide UART TX through tx_data / tx_start / tx_done_tick.
module tx_word_sequencer
  import tx_pkg::*;
#(
  parameter int NB_DATA  = 8,
  parameter int NB_WORD  = 32,
  parameter int NB_COUNT = 3
) (
  input  logic                clock,
  input  logic                reset,
  tx_word_sequencer_if.slave  word_if,
  input  logic                tx_done_tick,
  output logic [NB_DATA-1:0]  tx_data,
  output logic                tx_start,
  output logic                busy,
  output logic                word_done
);

  localparam int                  MAXB   = calc_maxb(NB_WORD, NB_DATA);
  localparam logic [NB_COUNT-1:0] MAXB_C = NB_COUNT'(MAXB);

  state_t              state_q, state_d;
  logic [NB_COUNT-1:0] idx_q, idx_d;
  logic [NB_COUNT-1:0] cnt_q, cnt_d;
  logic [NB_WORD-1:0]  word_q, word_d;
  logic [NB_DATA-1:0]  tx_data_q, tx_data_d;
  logic                word_ready_q, word_ready_d;
  logic                tx_start_q, tx_start_d;
  logic                busy_q, busy_d;
  logic                word_done_q, word_done_d;

  logic [NB_COUNT-1:0] eff_cnt;
  logic [NB_COUNT-1:0] idx_inc;
  logic [NB_DATA-1:0]  next_byte;

  // Clamp the requested count: 0 or anything past a full word means a full word.
  always_comb begin
    eff_cnt = word_if.byte_count;
    if (word_if.byte_count == '0 || word_if.byte_count > MAXB_C)
      eff_cnt = MAXB_C;
  end

  // Byte-select mux for the byte following the current one.
  always_comb begin
    idx_inc   = idx_q + NB_COUNT'(1);
    next_byte = '0;
    for (int i = 0; i < MAXB; i++) begin
      if (idx_inc == NB_COUNT'(i))
        next_byte = word_q[i*NB_DATA +: NB_DATA];
    end
  end

  // Next-state logic; outputs are derived from the next state so they register cleanly.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    word_d    = word_q;
    tx_data_d = tx_data_q;
    case (state_q)
      ST_IDLE: begin
        if (word_if.word_valid) begin
          word_d    = word_if.word_data;
          cnt_d     = eff_cnt;
          idx_d     = '0;
          tx_data_d = word_if.word_data[NB_DATA-1:0];
          state_d   = ST_START;
        end
      end
      // A tick here belongs to nothing we launched yet; ignore it.
      ST_START: state_d = ST_WAIT;
      ST_WAIT: begin
        if (tx_done_tick) begin
          if (idx_q == cnt_q - NB_COUNT'(1)) begin
            state_d = ST_DONE;
          end else begin
            idx_d     = idx_inc;
            tx_data_d = next_byte;
            state_d   = ST_START;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    word_ready_d = (state_d == ST_IDLE);
    tx_start_d   = (state_d == ST_START);
    word_done_d  = (state_d == ST_DONE);
    busy_d       = (state_d != ST_IDLE);
  end

  // State and registered outputs; reset aborts any word in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      cnt_q        <= '0;
      word_q       <= '0;
      tx_data_q    <= '0;
      word_ready_q <= 1'b1;
      tx_start_q   <= 1'b0;
      busy_q       <= 1'b0;
      word_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      word_q       <= word_d;
      tx_data_q    <= tx_data_d;
      word_ready_q <= word_ready_d;
      tx_start_q   <= tx_start_d;
      busy_q       <= busy_d;
      word_done_q  <= word_done_d;
    end
  end

  assign word_if.word_ready = word_ready_q;
  assign tx_data            = tx_data_q;
  assign tx_start           = tx_start_q;
  assign busy               = busy_q;
  assign word_done          = word_done_q;

endmodule

// File: tb/tb_tx_word_sequencer.sv
// Bench for tx_word_sequencer: a UART responder model, a byte-stream model of
// the expected output, a vector table, hand-written corner sequences and
// random words.
module tb_tx_word_sequencer;

  logic       clock = 1'b0;
  logic       reset;
  logic       tx_done_tick;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       busy;
  logic       word_done;

  tx_word_sequencer_if #(.NB_WORD(32), .NB_COUNT(3)) wif ();

  tx_word_sequencer #(.NB_DATA(8), .NB_WORD(32), .NB_COUNT(3)) dut (
    .clock        (clock),
    .reset        (reset),
    .word_if      (wif.slave),
    .tx_done_tick (tx_done_tick),
    .tx_data      (tx_data),
    .tx_start     (tx_start),
    .busy         (busy),
    .word_done    (word_done)
  );

  always #5 clock = ~clock;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] word;
    int          cnt;
    int          dly;
    int          exp_n;
    logic [31:0] exp_bytes;  // expected bytes, LSB first
  } vec_t;

  int         vectors = 0;
  int         miscompares = 0;
  int         cd = 0;
  int         dly_g = 5;
  bit         auto_en = 1'b1;
  bit         force_tick = 1'b0;
  bit         tick_drv = 1'b0;
  int         starts = 0;
  int         dones = 0;
  logic [7:0] obs_q[$];
  logic [7:0] hold_byte = 8'h00;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: effective byte count from the requested one.
  function automatic int eff_n(input int c);
    return (c == 0 || c > 4) ? 4 : c;
  endfunction

  // One clock: drive the UART tick, sample after the edge, log bytes.
  task automatic step();
    bit forced;
    forced = force_tick;
    force_tick = 1'b0;
    tick_drv = 1'b0;
    if (forced) tick_drv = 1'b1;
    else if (cd > 0) begin
      tick_drv = (cd == 1);
      cd--;
    end
    tx_done_tick = tick_drv;
    @(posedge clock);
    #1;
    if (tx_start) begin
      starts++;
      obs_q.push_back(tx_data);
      hold_byte = tx_data;
      if (auto_en) cd = dly_g;
    end else begin
      chk("tx_data_hold", {56'd0, tx_data}, {56'd0, hold_byte});
    end
    if (word_done) dones++;
    if (tick_drv && !forced) chk("tick_to_next", {63'd0, tx_start | word_done}, 64'd1);
  endtask

  task automatic check_bytes(input logic [31:0] exp_w, input int n, input int base);
    logic [7:0] e;
    for (int k = 0; k < n; k++) begin
      e = 8'((exp_w >> (8 * k)) & 32'hFF);
      if (base + k < obs_q.size()) chk("byte", {56'd0, obs_q[base + k]}, {56'd0, e});
      else chk("byte_missing", 64'd0, 64'd1);
    end
  endtask

  task automatic run_word(input logic [31:0] w, input int c, input int dly,
                          input int exp_n, input logic [31:0] exp_w);
    int n;
    obs_q.delete();
    starts = 0;
    dones = 0;
    dly_g = dly;
    auto_en = 1'b1;
    wif.word_data = w;
    wif.byte_count = 3'(c);
    wif.word_valid = 1'b1;
    chk("ready_idle", {63'd0, wif.word_ready}, 64'd1);
    step();
    wif.word_valid = 1'b0;
    chk("accept_to_start", {63'd0, tx_start}, 64'd1);
    chk("busy_after_accept", {63'd0, busy}, 64'd1);
    chk("ready_low", {63'd0, wif.word_ready}, 64'd0);
    n = 0;
    while (dones == 0 && n < 2000) begin
      step();
      n++;
    end
    chk("word_done_seen", 64'(dones), 64'd1);
    chk("done_follows_tick", {63'd0, tick_drv}, 64'd1);
    chk("busy_in_done", {63'd0, busy}, 64'd1);
    chk("start_count", 64'(starts), 64'(exp_n));
    check_bytes(exp_w, exp_n, 0);
    step();
    chk("ready_after_done", {63'd0, wif.word_ready}, 64'd1);
    chk("busy_after_done", {63'd0, busy}, 64'd0);
    chk("done_one_cycle", {63'd0, word_done}, 64'd0);
    repeat (6) step();
    chk("no_extra_start", 64'(starts), 64'(exp_n));
    chk("single_done", 64'(dones), 64'd1);
  endtask

  vec_t tbl[8];

  initial begin
    int n;
    logic [31:0] rw;
    int rc, rd;

    tbl[0] = '{32'hA1B2C3D4, 4, 5, 4, 32'hA1B2C3D4};
    tbl[1] = '{32'h11223344, 0, 5, 4, 32'h11223344};
    tbl[2] = '{32'h11223344, 7, 5, 4, 32'h11223344};
    tbl[3] = '{32'hDEADBEEF, 2, 5, 2, 32'h0000BEEF};
    tbl[4] = '{32'hCAFE00AB, 1, 3, 1, 32'h000000AB};
    tbl[5] = '{32'h7654321F, 3, 2, 3, 32'h0054321F};
    tbl[6] = '{32'h0F1E2D3C, 5, 4, 4, 32'h0F1E2D3C};
    tbl[7] = '{32'h80000001, 4, 2, 4, 32'h80000001};

    reset = 1'b1;
    tx_done_tick = 1'b0;
    wif.word_valid = 1'b0;
    wif.word_data = '0;
    wif.byte_count = '0;
    step();
    step();
    chk("rst_ready", {63'd0, wif.word_ready}, 64'd1);
    chk("rst_start", {63'd0, tx_start}, 64'd0);
    chk("rst_done", {63'd0, word_done}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_data", {56'd0, tx_data}, 64'd0);
    reset = 1'b0;
    step();

    // Stray tick while idle changes nothing.
    force_tick = 1'b1;
    step();
    chk("idle_tick_ready", {63'd0, wif.word_ready}, 64'd1);
    chk("idle_tick_busy", {63'd0, busy}, 64'd0);
    chk("idle_tick_start", {63'd0, tx_start}, 64'd0);
    step();

    for (int i = 0; i < 8; i++)
      run_word(tbl[i].word, tbl[i].cnt, tbl[i].dly, tbl[i].exp_n, tbl[i].exp_bytes);

    // Tick coinciding with tx_start must not advance the byte index.
    obs_q.delete();
    starts = 0;
    dones = 0;
    dly_g = 4;
    auto_en = 1'b1;
    wif.word_data = 32'h55667788;
    wif.byte_count = 3'd3;
    wif.word_valid = 1'b1;
    step();
    wif.word_valid = 1'b0;
    chk("st_tick_start", {63'd0, tx_start}, 64'd1);
    force_tick = 1'b1;
    step();
    chk("st_tick_no_restart", {63'd0, tx_start}, 64'd0);
    chk("st_tick_busy", {63'd0, busy}, 64'd1);
    n = 0;
    while (dones == 0 && n < 2000) begin
      step();
      n++;
    end
    chk("st_tick_done", 64'(dones), 64'd1);
    chk("st_tick_starts", 64'(starts), 64'd3);
    check_bytes(32'h00667788, 3, 0);
    repeat (3) step();

    // Reset during WAIT of byte 2, then a late tick.
    obs_q.delete();
    starts = 0;
    dones = 0;
    dly_g = 5;
    auto_en = 1'b1;
    wif.word_data = 32'hA1B2C3D4;
    wif.byte_count = 3'd4;
    wif.word_valid = 1'b1;
    step();
    wif.word_valid = 1'b0;
    n = 0;
    while (starts < 2 && n < 2000) begin
      step();
      n++;
    end
    chk("rst_mid_two_starts", 64'(starts), 64'd2);
    step();
    chk("rst_mid_in_wait", {63'd0, busy & ~tx_start}, 64'd1);
    reset = 1'b1;
    auto_en = 1'b0;
    hold_byte = 8'h00;
    step();
    chk("rst_mid_ready", {63'd0, wif.word_ready}, 64'd1);
    chk("rst_mid_busy", {63'd0, busy}, 64'd0);
    chk("rst_mid_start", {63'd0, tx_start}, 64'd0);
    reset = 1'b0;
    cd = 0;
    force_tick = 1'b1;
    step();
    repeat (8) step();
    chk("late_tick_no_start", 64'(starts), 64'd2);
    chk("late_tick_no_done", 64'(dones), 64'd0);
    chk("late_tick_ready", {63'd0, wif.word_ready}, 64'd1);
    chk("late_tick_busy", {63'd0, busy}, 64'd0);

    // Back-to-back words with word_valid held high.
    obs_q.delete();
    starts = 0;
    dones = 0;
    dly_g = 3;
    auto_en = 1'b1;
    wif.word_data = 32'h01020304;
    wif.byte_count = 3'd4;
    wif.word_valid = 1'b1;
    step();
    wif.word_data = 32'h05060708;
    n = 0;
    while (dones == 0 && n < 2000) begin
      step();
      n++;
    end
    chk("b2b_first_done", 64'(dones), 64'd1);
    step();
    chk("b2b_ready_after_done", {63'd0, wif.word_ready}, 64'd1);
    chk("b2b_no_start_idle", {63'd0, tx_start}, 64'd0);
    step();
    wif.word_valid = 1'b0;
    chk("b2b_second_start", {63'd0, tx_start}, 64'd1);
    chk("b2b_second_byte0", {56'd0, tx_data}, 64'h08);
    n = 0;
    while (dones < 2 && n < 2000) begin
      step();
      n++;
    end
    chk("b2b_second_done", 64'(dones), 64'd2);
    chk("b2b_starts", 64'(starts), 64'd8);
    check_bytes(32'h01020304, 4, 0);
    check_bytes(32'h05060708, 4, 4);
    repeat (3) step();

    // Random words checked against the byte-stream model.
    for (int i = 0; i < 12; i++) begin
      rw = $urandom;
      rc = int'($urandom_range(0, 7));
      rd = int'($urandom_range(2, 6));
      run_word(rw, rc, rd, eff_n(rc), rw);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
